// File: rtl/fifo_stream_adapter.sv
// Read-side adapter for async_fifo: turns the pop interface into a valid/ready
// stream through a 2-entry skid buffer, frames fixed-length packets and counts words.
module fifo_stream_adapter #(
  parameter int BITS     = 32,
  parameter int PKT_LEN  = 16,
  parameter int CNT_BITS = 32
) (
  input  logic                read_clk,
  input  logic                read_rst_n,
  input  logic                flush,
  output logic                p_read_en,
  input  logic                p_read_empty,
  input  logic [BITS-1:0]     p_read_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BITS-1:0]     m_data,
  output logic                m_last,
  output logic [CNT_BITS-1:0] word_count
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [BITS-1:0] mem [2];
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            inflight;
  logic            discard;
  logic [15:0]     beat;
  logic            pop_out;
  logic            capture;
  logic [2:0]      credit;

  assign m_valid = (count != 2'd0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign m_last  = m_valid && (beat == LAST_BEAT);
  assign pop_out = m_valid & m_ready;

  // Occupancy the buffer will have once the in-flight word lands and this
  // cycle's handoff leaves; a new pop is only issued if it still fits.
  assign credit    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop_out};
  assign p_read_en = read_rst_n & ~flush & ~p_read_empty & (credit < 3'd2);

  // A word arriving during a flush (or flagged by a previous flush) is dropped.
  assign capture = inflight & ~discard & ~flush;

  always_ff @(posedge read_clk) begin
    if (!read_rst_n) begin
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      inflight <= p_read_en;
      discard  <= flush & (inflight | p_read_en);
    end
  end

  always_ff @(posedge read_clk) begin
    if (!read_rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
    end else if (capture) begin
      mem[wr_ptr] <= p_read_data;
      wr_ptr      <= ~wr_ptr;
    end
  end

  always_ff @(posedge read_clk) begin
    if (!read_rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      if (pop_out) begin
        rd_ptr <= ~rd_ptr;
      end
      if (capture && !pop_out) begin
        count <= count + 2'd1;
      end else if (!capture && pop_out) begin
        count <= count - 2'd1;
      end
    end
  end

  // Packet position restarts on flush; the delivered-word total does not.
  always_ff @(posedge read_clk) begin
    if (!read_rst_n) begin
      beat       <= 16'd0;
      word_count <= '0;
    end else if (flush) begin
      beat <= 16'd0;
    end else if (pop_out) begin
      beat       <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
      word_count <= word_count + CNT_BITS'(1);
    end
  end

endmodule

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Read-side consumer of async_fifo, in the read_clk domain.
- Drives the FIFO's p_read_en / p_read_empty / p_read_data pop interface.
- Converts it to a valid/ready stream with a 2-entry skid buffer, sustaining one word per cycle under backpressure.
- Frames the stream into fixed-length packets (m_last), keeps a delivered-word counter and supports synchronous flush.

Parameters:
- BITS, 32, data width; must equal the async_fifo BITS.
- PKT_LEN, 16, words per packet; m_last marks word PKT_LEN; legal range 1..65535.
- CNT_BITS, 32, width of word_count.

Ports:
- read_clk  input  1  Clock; the FIFO read clock.
- read_rst_n  input  1  Active-low reset, synchronous to read_clk.
- flush  input  1  Synchronous flush: discard buffered and in-flight words.
- p_read_en  output  1  FIFO pop request.
- p_read_empty  input  1  FIFO empty flag.
- p_read_data  input  BITS  FIFO data; valid the cycle after an accepted pop.
- m_valid  output  1  Output word valid.
- m_ready  input  1  Downstream accept.
- m_data  output  BITS  Output word.
- m_last  output  1  Last word of a packet; qualified by m_valid.
- word_count  output  CNT_BITS  Total words handed off since reset.

Behaviour:
- Interface: one clock (read_clk); reset (read_rst_n) is synchronous and active-low. All state updates on the rising edge of read_clk.
- Reset (read_rst_n=0 at an edge):
  - Buffer count=0, inflight=0, discard=0, beat counter=0, word_count=0.
  - Outputs: m_valid=0, m_data=0, m_last=0.
  - p_read_en is held 0 whenever read_rst_n=0, regardless of p_read_empty.
- FIFO contract:
  - A pop is accepted when p_read_en=1 and p_read_empty=0 at an edge.
  - The popped word appears on p_read_data for the following cycle and is captured at the next edge.
  - The adapter never asserts p_read_en while p_read_empty=1.
- Credit rule:
  - pop_out = m_valid & m_ready.
  - p_read_en = read_rst_n & !flush & !p_read_empty & ((count + inflight - pop_out) < 2).
  - inflight is a 1-bit register: it is set at the edge of an accepted pop and captures data at the next edge.
  - The buffer can therefore never overflow.
  - Steady state (count=1, inflight=1, m_ready=1) issues one pop per cycle: full throughput.
- Buffer:
  - 2-entry FIFO, head on m_data.
  - m_valid = (count != 0).
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
  - Simultaneous capture and pop_out leaves count unchanged and preserves order.
  - First-word latency: pop accepted at edge N → word captured at edge N+1 → m_valid=1 in cycle N+1.
- Packet framing:
  - The beat counter (0..PKT_LEN-1) advances on pop_out and wraps to 0 after PKT_LEN-1.
  - m_last = m_valid & (beat == PKT_LEN-1).
  - With PKT_LEN=1, m_last equals m_valid.
- word_count:
  - Increments by 1 on each pop_out.
  - Wraps modulo 2^CNT_BITS.
  - Not cleared by flush.
- Flush (flush=1 at an edge):
  - count=0 and beat=0; no pop_out is counted that cycle.
  - If inflight=1, or a pop was accepted at that same edge, the discard flag is set and the arriving word is dropped, not captured.
  - While flush=1, p_read_en=0.
  - Normal popping resumes the cycle after flush deasserts.
- Reset mid-operation: reset overrides flush and all traffic. A word in flight at reset is dropped, because inflight is cleared.
- Empty mid-stream: m_valid drains the remaining buffered words, then stays 0. Pops resume automatically when p_read_empty falls.

Test Plan:
- Reset: FIFO holds 4 words, read_rst_n=0 for 4 cycles → p_read_en=0, m_valid=0, m_data=0, m_last=0, word_count=0 throughout.
- Streaming: FIFO preloaded 0..31, m_ready=1, PKT_LEN=16 → m_valid one cycle after the first pop, then 32 consecutive beats with m_data=0..31; m_last on data 15 and 31; word_count=32; p_read_en never high while p_read_empty=1.
- Backpressure: FIFO preloaded 0..7, m_ready=0 for 10 cycles → exactly 2 pops issued, m_data holds 0. Then m_ready=1 → words 0..7 in order, none lost or duplicated.
- Empty mid-stream: FIFO holds 5 words, m_ready=1 → m_valid deasserts after word 4. Write 3 more → words 5..7 follow, with m_last still on the 16th beat overall.
- Flush with pop in flight: assert flush the cycle after a pop, with 1 word buffered → both words discarded, word_count unchanged. The next delivered word is the following FIFO entry, and m_last arrives 16 beats later.
- Random: m_ready random 50% for 10,000 cycles with SEED=7, writes from the async_fifo testbench → the scoreboard of 0..N-1 shows zero errors and word_count equals the number of words read.
